// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the fetch port and the data port; data wins by default.
// Define ARB_FAIR_EN to cap consecutive data grants (FAIR_LIMIT) while fetch is waiting.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_f,
    output logic        stall_m
);
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end
    if (FAIR_LIMIT < 1) begin : g_bad_fair
        $error("mem_port_arbiter: FAIR_LIMIT must be at least 1");
    end

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_e;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic issue;
    logic done;
    logic grant_data;
    logic fair_hold;

`ifdef ARB_FAIR_EN
    localparam int FW = $clog2(FAIR_LIMIT + 1);
    logic [FW-1:0] fair_q, fair_d;

    // Once the budget is spent, a waiting fetch takes the next arbitration.
    assign fair_hold = if_req && (fair_q >= FW'(FAIR_LIMIT));

    always_comb begin
        fair_d = fair_q;
        if (issue) begin
            if (grant_data && if_req) fair_d = fair_q + 1'b1;
            else                      fair_d = '0;
        end
    end
`else
    assign fair_hold = 1'b0;
`endif

    assign grant_data = dm_req && !fair_hold;
    // Issue happens in the IDLE cycle itself, so the strobe is combinational on the request.
    assign issue      = !rst && (state_q == IDLE) && (if_req || dm_req);
    assign done       = !rst && (state_q == BUSY) && (cnt_q == 4'd1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (issue) begin
            state_d = BUSY;
            cnt_d   = 4'(MEM_LAT);
            if (grant_data) begin
                owner_d = OWN_DATA;
                we_d    = dm_we;
                addr_d  = dm_addr;
                wdata_d = dm_wdata;
            end else begin
                owner_d = OWN_FETCH;
                we_d    = 1'b0;
                addr_d  = if_addr;
                wdata_d = '0;
            end
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - 4'd1;
            if (done) begin
                state_d = IDLE;
                owner_d = OWN_NONE;
                we_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef ARB_FAIR_EN
            fair_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef ARB_FAIR_EN
            fair_q  <= fair_d;
`endif
        end
    end

    assign mem_en    = issue;
    assign mem_we    = rst ? 1'b0 : (issue ? we_d : we_q);
    assign mem_addr  = rst ? '0 : (issue ? addr_d : addr_q);
    assign mem_wdata = rst ? '0 : (issue ? wdata_d : wdata_q);

    assign if_ready  = done && (owner_q == OWN_FETCH);
    assign dm_ready  = done && (owner_q == OWN_DATA);
    assign if_rdata  = if_ready ? mem_rdata : '0;
    assign dm_rdata  = dm_ready ? mem_rdata : '0;

    assign stall_f   = !rst && if_req && !if_ready;
    assign stall_m   = !rst && dm_req && !dm_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with MEM_LAT = 1, 2, 3, each with its own memory model.
module tb_mem_port_arbiter;
    localparam int N = 3;
    localparam logic [31:0] F0 = 32'h0040_0000, F1 = 32'h0040_0004, F2 = 32'h0040_0008;
    localparam logic [31:0] D1 = 32'h1000_0004, D2 = 32'h1000_0010, D3 = 32'h1000_0008;
    localparam logic [31:0] I0 = 32'h2008_0005, I1 = 32'h0000_0013, I2 = 32'h0000_0033;
    localparam logic [31:0] V1 = 32'h1234_5678, W2 = 32'hCAFE_F00D, W3 = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [N];
    logic        if_req [N], dm_req [N], dm_we [N];
    logic [31:0] if_addr [N], dm_addr [N], dm_wdata [N];
    logic [31:0] if_rdata [N], dm_rdata [N], mem_addr [N], mem_wdata [N], mem_rdata [N];
    logic        if_ready [N], dm_ready [N], mem_en [N], mem_we [N], stall_f [N], stall_m [N];

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            F0:      return I0;
            F1:      return I1;
            F2:      return I2;
            D1:      return V1;
            default: return 32'h0;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = g + 1;
        int          age = 0;
        logic [31:0] rd_q = '0;
        logic [15:0] wv = '0;
        logic [31:0] wd [16];
        logic [3:0]  ix;

        mem_port_arbiter #(.MEM_LAT(L), .FAIR_LIMIT(4)) u_dut (
            .clk(clk), .rst(rst[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
            .dm_rdata(dm_rdata[g]), .dm_ready(dm_ready[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]), .stall_f(stall_f[g]), .stall_m(stall_m[g])
        );

        assign ix = {mem_addr[g][28], mem_addr[g][4:2]};

        // Read data is only valid exactly L cycles after the strobe; garbage otherwise.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                age  <= 1;
                rd_q <= wv[ix] ? wd[ix] : rom(mem_addr[g]);
                if (mem_we[g]) begin
                    wv[ix] <= 1'b1;
                    wd[ix] <= mem_wdata[g];
                end
            end else if (age != 0 && age < 64) begin
                age <= age + 1;
            end
        end
        assign mem_rdata[g] = (age == L) ? rd_q : 32'hBAD0_BAD0;
    end

    typedef struct {
        logic        rst, if_req, dm_req, dm_we;
        logic [31:0] if_addr, dm_addr, dm_wdata;
        logic        e_en, e_we, e_ifr, e_dmr, e_sf, e_sm;
        logic        chk_a;
        logic [31:0] e_addr;
        logic        chk_w;
        logic [31:0] e_wdata;
        logic        chk_rd;
        logic [31:0] e_if_rd, e_dm_rd;
    } vec_t;

    vec_t tv [15];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input logic ir, input logic [31:0] ia, input logic dr,
                         input logic we, input logic [31:0] da, input logic [31:0] wdat);
        if_req[g]   = ir;
        if_addr[g]  = ia;
        dm_req[g]   = dr;
        dm_we[g]    = we;
        dm_addr[g]  = da;
        dm_wdata[g] = wdat;
    endtask

    task automatic chk_quiet(input int g, input string tag);
        chk1({tag, ".mem_en"}, mem_en[g], 1'b0);
        chk1({tag, ".mem_we"}, mem_we[g], 1'b0);
        chk32({tag, ".mem_addr"}, mem_addr[g], 32'h0);
        chk32({tag, ".mem_wdata"}, mem_wdata[g], 32'h0);
        chk1({tag, ".if_ready"}, if_ready[g], 1'b0);
        chk1({tag, ".dm_ready"}, dm_ready[g], 1'b0);
        chk32({tag, ".if_rdata"}, if_rdata[g], 32'h0);
        chk32({tag, ".dm_rdata"}, dm_rdata[g], 32'h0);
        chk1({tag, ".stall_f"}, stall_f[g], 1'b0);
        chk1({tag, ".stall_m"}, stall_m[g], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] got;
        logic [9:0] expg;
        int ng;

        // rst if dm we | if_addr dm_addr wdata | en we ifr dmr sf sm | chk_a addr | chk_w wdata | chk_rd if_rd dm_rd
        tv[0]  = '{1,0,0,0, 0, 0, 0,   0,0,0,0,0,0, 1,0,  1,0,  1,0,0};
        tv[1]  = '{0,0,0,0, 0, 0, 0,   0,0,0,0,0,0, 0,0,  0,0,  1,0,0};
        tv[2]  = '{0,1,0,0, F0,0, 0,   1,0,0,0,1,0, 1,F0, 0,0,  1,0,0};
        tv[3]  = '{0,1,0,0, F0,0, 0,   0,0,1,0,0,0, 1,F0, 0,0,  1,I0,0};
        tv[4]  = '{0,0,0,0, 0, 0, 0,   0,0,0,0,0,0, 0,0,  0,0,  1,0,0};
        tv[5]  = '{0,1,1,0, F1,D1,0,   1,0,0,0,1,1, 1,D1, 0,0,  1,0,0};
        tv[6]  = '{0,1,1,0, F1,D1,0,   0,0,0,1,1,0, 1,D1, 0,0,  1,0,V1};
        tv[7]  = '{0,1,0,0, F1,D1,0,   1,0,0,0,1,0, 1,F1, 0,0,  1,0,0};
        tv[8]  = '{0,1,0,0, F1,0, 0,   0,0,1,0,0,0, 1,F1, 0,0,  1,I1,0};
        tv[9]  = '{0,0,0,0, 0, 0, 0,   0,0,0,0,0,0, 0,0,  0,0,  1,0,0};
        tv[10] = '{0,0,1,1, 0, D2,W2,  1,1,0,0,0,1, 1,D2, 1,W2, 1,0,0};
        tv[11] = '{0,0,1,1, 0, D2,W2,  0,1,0,1,0,0, 1,D2, 1,W2, 0,0,0};
        tv[12] = '{0,0,1,0, 0, D2,0,   1,0,0,0,0,1, 1,D2, 0,0,  1,0,0};
        tv[13] = '{0,0,1,0, 0, D2,0,   0,0,0,1,0,0, 1,D2, 0,0,  1,0,W2};
        tv[14] = '{0,0,0,0, 0, 0, 0,   0,0,0,0,0,0, 0,0,  0,0,  1,0,0};

        for (int g = 0; g < N; g++) begin
            rst[g] = 1'b1;
            drive(g, 0, 0, 0, 0, 0, 0);
        end
        repeat (3) tick();
        rst[1] = 1'b0;
        rst[2] = 1'b0;

        // Table: MEM_LAT=1, fetch-only, both-request, write then readback.
        for (int i = 0; i < 15; i++) begin
            tick();
            rst[0] = tv[i].rst;
            drive(0, tv[i].if_req, tv[i].if_addr, tv[i].dm_req, tv[i].dm_we, tv[i].dm_addr, tv[i].dm_wdata);
            @(negedge clk);
            chk1($sformatf("v%0d.mem_en", i), mem_en[0], tv[i].e_en);
            chk1($sformatf("v%0d.mem_we", i), mem_we[0], tv[i].e_we);
            chk1($sformatf("v%0d.if_ready", i), if_ready[0], tv[i].e_ifr);
            chk1($sformatf("v%0d.dm_ready", i), dm_ready[0], tv[i].e_dmr);
            chk1($sformatf("v%0d.stall_f", i), stall_f[0], tv[i].e_sf);
            chk1($sformatf("v%0d.stall_m", i), stall_m[0], tv[i].e_sm);
            if (tv[i].chk_a) chk32($sformatf("v%0d.mem_addr", i), mem_addr[0], tv[i].e_addr);
            if (tv[i].chk_w) chk32($sformatf("v%0d.mem_wdata", i), mem_wdata[0], tv[i].e_wdata);
            if (tv[i].chk_rd) begin
                chk32($sformatf("v%0d.if_rdata", i), if_rdata[0], tv[i].e_if_rd);
                chk32($sformatf("v%0d.dm_rdata", i), dm_rdata[0], tv[i].e_dm_rd);
            end
        end

        // Both requests held: record which port each strobe serves.
`ifdef ARB_FAIR_EN
        expg = 10'b0111101111;
`else
        expg = 10'b1111111111;
`endif
        got = '0;
        ng  = 0;
        tick();
        drive(0, 1, F0, 1, 0, D1, 0);
        for (int c = 0; c < 60 && ng < 10; c++) begin
            @(negedge clk);
            if (mem_en[0]) begin
                got[ng] = (mem_addr[0] == D1);
                ng++;
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk32("fair.grant_count", ng, 10);
        for (int i = 0; i < ng; i++) chk1($sformatf("fair.grant%0d_is_data", i), got[i], expg[i]);
        repeat (2) tick();

        // MEM_LAT=3 write, held controls, then readback.
        drive(2, 0, 0, 1, 1, D3, W3);
        @(negedge clk);
        chk1("wr.T.mem_en", mem_en[2], 1'b1);
        chk1("wr.T.mem_we", mem_we[2], 1'b1);
        chk32("wr.T.mem_addr", mem_addr[2], D3);
        chk32("wr.T.mem_wdata", mem_wdata[2], W3);
        for (int k = 1; k <= 2; k++) begin
            tick();
            @(negedge clk);
            chk1($sformatf("wr.T%0d.dm_ready", k), dm_ready[2], 1'b0);
            chk1($sformatf("wr.T%0d.mem_en", k), mem_en[2], 1'b0);
            chk1($sformatf("wr.T%0d.mem_we", k), mem_we[2], 1'b1);
            chk32($sformatf("wr.T%0d.mem_addr", k), mem_addr[2], D3);
        end
        tick();
        @(negedge clk);
        chk1("wr.T3.dm_ready", dm_ready[2], 1'b1);
        tick();
        drive(2, 0, 0, 1, 0, D3, 0);
        @(negedge clk);
        chk1("rb.T.mem_en", mem_en[2], 1'b1);
        chk1("rb.T.mem_we", mem_we[2], 1'b0);
        repeat (2) tick();
        @(negedge clk);
        chk1("rb.T2.dm_ready", dm_ready[2], 1'b0);
        tick();
        @(negedge clk);
        chk1("rb.T3.dm_ready", dm_ready[2], 1'b1);
        chk32("rb.T3.dm_rdata", dm_rdata[2], W3);
        tick();
        drive(2, 0, 0, 0, 0, 0, 0);

        // Reset one cycle into a MEM_LAT=3 fetch: access abandoned, no ready.
        tick();
        drive(2, 1, F2, 0, 0, 0, 0);
        @(negedge clk);
        chk1("rstmid.T.mem_en", mem_en[2], 1'b1);
        tick();
        rst[2] = 1'b1;
        drive(2, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("rstmid.T1.if_ready", if_ready[2], 1'b0);
        tick();
        rst[2] = 1'b0;
        @(negedge clk);
        chk_quiet(2, "rstmid.T2");
        for (int k = 3; k <= 4; k++) begin
            tick();
            @(negedge clk);
            chk1($sformatf("rstmid.T%0d.if_ready", k), if_ready[2], 1'b0);
            chk1($sformatf("rstmid.T%0d.mem_en", k), mem_en[2], 1'b0);
        end
        tick();
        drive(2, 1, F2, 0, 0, 0, 0);
        @(negedge clk);
        chk1("rstmid.new.mem_en", mem_en[2], 1'b1);
        chk32("rstmid.new.mem_addr", mem_addr[2], F2);
        repeat (2) tick();
        @(negedge clk);
        chk1("rstmid.new.T2.if_ready", if_ready[2], 1'b0);
        tick();
        @(negedge clk);
        chk1("rstmid.new.T3.if_ready", if_ready[2], 1'b1);
        chk32("rstmid.new.T3.if_rdata", if_rdata[2], I2);
        tick();
        drive(2, 0, 0, 0, 0, 0, 0);

        // MEM_LAT=2 data read whose request drops mid-access; fetch arrives meanwhile.
        drive(1, 0, 0, 1, 0, D1, 0);
        @(negedge clk);
        chk1("drop.T.mem_en", mem_en[1], 1'b1);
        tick();
        drive(1, 1, F0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("drop.T1.mem_en", mem_en[1], 1'b0);
        chk1("drop.T1.stall_f", stall_f[1], 1'b1);
        chk1("drop.T1.dm_ready", dm_ready[1], 1'b0);
        tick();
        @(negedge clk);
        chk1("drop.T2.dm_ready", dm_ready[1], 1'b1);
        chk32("drop.T2.dm_rdata", dm_rdata[1], V1);
        chk1("drop.T2.stall_m", stall_m[1], 1'b0);
        chk1("drop.T2.mem_en", mem_en[1], 1'b0);
        chk1("drop.T2.stall_f", stall_f[1], 1'b1);
        tick();
        @(negedge clk);
        chk1("drop.T3.mem_en", mem_en[1], 1'b1);
        chk32("drop.T3.mem_addr", mem_addr[1], F0);
        tick();
        @(negedge clk);
        chk1("drop.T4.if_ready", if_ready[1], 1'b0);
        tick();
        @(negedge clk);
        chk1("drop.T5.if_ready", if_ready[1], 1'b1);
        chk32("drop.T5.if_rdata", if_rdata[1], I0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
